// File: rtl/sieve_pkg.sv
// Shared types and helpers for the multiple-sieve datapath.
package sieve_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest divisor the sieve can select; mask bit k maps to divisor k+MIN_DIV.
    localparam int MIN_DIV = 2;

    // Bits needed to hold a residue 0..d-1.
    function automatic int res_w(input int d);
        return $clog2(d);
    endfunction

endpackage

// File: rtl/multiple_sieve_seq_mod_counter.sv
// Wrapping residue counter: tracks n mod D without a divider.
module mod_counter
    import sieve_pkg::*;
#(
    parameter int D = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic zero
);

    localparam int W = res_w(D);
    localparam logic [W-1:0] LAST = W'(D - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] r;

    // Residue follows n: cleared at run start, advanced with each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (clr) begin
            r <= '0;
        end else if (inc) begin
            r <= (r == LAST) ? '0 : r + ONE;
        end
    end

    assign zero = (r == '0);

endmodule

// File: rtl/multiple_sieve_seq.sv
// Sequential multiple-finder: streams n = 0..limit with a hit flag, builds a bitmap and hit count.
module multiple_sieve_seq
    import sieve_pkg::*;
#(
    parameter int N_W     = 5,
    parameter int MAX_DIV = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_W-1:0]       limit,
    input  logic [MAX_DIV-2:0]   div_mask,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_W-1:0]       out_num,
    output logic                 out_hit,
    output logic                 out_last,
    output logic [2**N_W-1:0]    bitmap,
    output logic [N_W:0]         hit_count,
    output logic                 done
);

    localparam int NDIV = MAX_DIV - MIN_DIV + 1;
    localparam logic [N_W-1:0] N_ONE = N_W'(1);

    state_t               state, state_next;
    logic [N_W-1:0]       n_reg;
    logic [N_W-1:0]       limit_reg;
    logic [MAX_DIV-2:0]   mask_reg;
    logic [NDIV-1:0]      zeros;
    logic                 start_acc;
    logic                 xfer;
    logic                 hit_raw;
    logic                 last_raw;

    // One residue counter per selectable divisor.
    for (genvar k = 0; k < NDIV; k++) begin : g_div
        mod_counter #(.D(k + MIN_DIV)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start_acc),
            .inc   (xfer),
            .zero  (zeros[k])
        );
    end

    assign hit_raw  = |(mask_reg & zeros);
    assign last_raw = (n_reg == limit_reg);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; hit/last are masked outside RUN so idle outputs read 0.
    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        xfer       = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_hit    = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_hit   = hit_raw;
                out_last  = last_raw;
                xfer      = out_ready;
                if (out_ready && last_raw) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run datapath: latch operands on start, then record each accepted beat and step n up to the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg     <= '0;
            limit_reg <= '0;
            mask_reg  <= '0;
            bitmap    <= '0;
            hit_count <= '0;
        end else if (start_acc) begin
            n_reg     <= '0;
            limit_reg <= limit;
            mask_reg  <= div_mask;
            bitmap    <= '0;
            hit_count <= '0;
        end else if (xfer) begin
            bitmap[n_reg] <= hit_raw;
            hit_count     <= hit_count + {{N_W{1'b0}}, hit_raw};
            if (!last_raw) begin
                n_reg <= n_reg + N_ONE;
            end
        end
    end

    assign out_num = n_reg;

endmodule

// File: tb/tb_multiple_sieve_seq.sv
// Randomised self-checking bench for multiple_sieve_seq against a modulo-based reference.
module tb_multiple_sieve_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  limit;
    logic [7:0]  div_mask;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_num;
    logic        out_hit;
    logic        out_last;
    logic [31:0] bitmap;
    logic [5:0]  hit_count;
    logic        done;

    int checks;
    int failures;

    logic [31:0] expBitmap;
    int          expCount;

    multiple_sieve_seq #(.N_W(5), .MAX_DIV(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .limit     (limit),
        .div_mask  (div_mask),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_hit   (out_hit),
        .out_last  (out_last),
        .bitmap    (bitmap),
        .hit_count (hit_count),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: n is a hit if some selected divisor divides it.
    function automatic int refHit(input int n, input int msk);
        for (int d = 2; d <= 9; d++) begin
            if (((msk >> (d - 2)) & 1) == 1 && (n % d) == 0) return 1;
        end
        return 0;
    endfunction

    function automatic int popcount32(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    // Runs one sieve pass. mode: 0 ready high, 1 random ready, 2 stall 3 cycles at n=4,
    // 3 re-pulse start mid-run, 4 async reset at n=7.
    task automatic applyStimulus(input int lim, input int msk, input int mode);
        int expN;
        int cycles;
        int stallCnt;
        bit finished;
        bit rdy;
        @(negedge clk);
        limit     = 5'(lim);
        div_mask  = 8'(msk);
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        limit     = 5'($urandom);
        div_mask  = 8'($urandom);
        expN      = 0;
        expCount  = 0;
        expBitmap = '0;
        cycles    = 0;
        stallCnt  = 0;
        finished  = 1'b0;
        while (!finished && cycles < 400) begin
            checkOutput("valid", 64'(out_valid), 64'd1);
            checkOutput("busy", 64'(busy), 64'd1);
            checkOutput("num", 64'(out_num), 64'(expN));
            checkOutput("hit", 64'(out_hit), 64'(refHit(expN, msk)));
            checkOutput("last", 64'(out_last), 64'(expN == lim));
            checkOutput("done_run", 64'(done), 64'd0);
            if (mode == 4 && expN == 7) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_valid", 64'(out_valid), 64'd0);
                checkOutput("rst_num", 64'(out_num), 64'd0);
                checkOutput("rst_hit", 64'(out_hit), 64'd0);
                checkOutput("rst_last", 64'(out_last), 64'd0);
                checkOutput("rst_bitmap", 64'(bitmap), 64'd0);
                checkOutput("rst_count", 64'(hit_count), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("rst_nodone", 64'(done), 64'd0);
                end
                rst_n = 1'b1;
                return;
            end
            rdy   = 1'b1;
            start = 1'b0;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && expN == 4 && stallCnt < 3) begin
                rdy = 1'b0;
                stallCnt++;
            end
            if (mode == 3 && expN == 3) begin
                start    = 1'b1;
                limit    = 5'd1;
                div_mask = 8'h00;
            end
            out_ready = rdy;
            if (rdy) begin
                expBitmap[expN] = 1'(refHit(expN, msk));
                expCount += refHit(expN, msk);
                if (expN == lim) finished = 1'b1;
                else expN++;
            end
            @(negedge clk);
            cycles++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (!finished) begin
            checkOutput("timeout", 64'd0, 64'd1);
            return;
        end
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("busy_done", 64'(busy), 64'd0);
        checkOutput("valid_done", 64'(out_valid), 64'd0);
        checkOutput("bitmap", 64'(bitmap), 64'(expBitmap));
        checkOutput("count", 64'(hit_count), 64'(expCount));
        checkOutput("count_pop", 64'(hit_count), 64'(popcount32(bitmap)));
        @(negedge clk);
        checkOutput("done_once", 64'(done), 64'd0);
        checkOutput("bitmap_hold", 64'(bitmap), 64'(expBitmap));
        checkOutput("count_hold", 64'(hit_count), 64'(expCount));
    endtask

    // Directed scenarios, reset behaviour, then a full mask sweep with random backpressure.
    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        limit     = '0;
        div_mask  = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_last", 64'(out_last), 64'd0);
        checkOutput("reset_bitmap", 64'(bitmap), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        applyStimulus(10, 8'b0000_0001, 0);
        checkOutput("t1_bitmap", 64'(bitmap), 64'h555);
        checkOutput("t1_count", 64'(hit_count), 64'd6);

        applyStimulus(31, 8'b0000_1010, 0);
        checkOutput("t2_count", 64'(hit_count), 64'd15);
        checkOutput("t2_bit15", 64'(bitmap[15]), 64'd1);
        checkOutput("t2_bit7", 64'(bitmap[7]), 64'd0);

        applyStimulus(5, 8'h00, 1);
        checkOutput("t3_count", 64'(hit_count), 64'd0);
        checkOutput("t3_bitmap", 64'(bitmap), 64'd0);

        applyStimulus(12, 8'b0000_0011, 2);
        checkOutput("t4_count", 64'(hit_count), 64'd9);

        applyStimulus(20, 8'b0010_0100, 3);
        applyStimulus(25, 8'b0000_0110, 4);

        applyStimulus(0, 8'b0000_0001, 0);
        checkOutput("t5_bitmap", 64'(bitmap), 64'd1);
        checkOutput("t5_count", 64'(hit_count), 64'd1);

        for (int m = 0; m < 256; m++) begin
            applyStimulus(31, m, 1);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
